mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Main control FSM that sequences the shared MIPS datapath (register file, ALU32bit, ALU control,
//  single memory) over several cycles per instruction, replacing per-type hardwired control values.
//  Sits beside the core; consumes opcode + ALU zero flag, drives every datapath enable/mux select.
//  Handles variable-latency memory via a ready handshake and flags illegal opcodes / memory timeouts.
// PARAMETERS
//  TIMEOUT    16  max cycles a memory state waits for mem_ready before entering ERROR
//  RETIRE_W   32  width of retired-instruction counter
// PORTS
//  clock          in   1        system clock, all state changes on posedge
//  reset          in   1        synchronous, active-high
//  opcode         in   6        instruction[31:26] from IR (valid from DECODE onward)
//  zero_flag      in   1        ALU zero/compare flag
//  mem_ready      in   1        memory completes current access this cycle
//  IorD           out  1        0: memory addr = PC, 1: ALU result register
//  MemRead        out  1        memory read strobe
//  MemWrite       out  1        memory write strobe
//  IRWrite        out  1        load instruction register
//  RegDst         out  1        1: write rd, 0: write rt
//  RegWrite       out  1        register file write enable
//  MemToReg       out  1        1: write-back from memory data register
//  ALUSrcA        out  1        0: PC, 1: rs_content
//  ALUSrcB        out  2        00 rt, 01 const 1, 10 sign-ext imm, 11 reserved
//  ALUop          out  2        00 add, 01 sub (branch), 10 funct-decoded (to ALU control)
//  PCWrite        out  1        unconditional PC load
//  PCWriteCond    out  1        PC load qualified by zero_flag externally
//  PCSrc          out  2        00 ALU out, 01 ALUOut reg (branch target), 10 jump {PC[31:26],addr}
//  instr_retired  out  1        1-cycle pulse when an instruction completes
//  retire_count   out  RETIRE_W retired instructions since reset, wraps to 0
//  illegal_op     out  1        sticky; set on undecodable opcode
//  mem_timeout    out  1        sticky; set on TIMEOUT expiry
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, retire_count=0, stickies=0; all outputs 0 while reset high.
//  - Moore outputs decoded from state; only IRWrite/PCWrite in FETCH gated by mem_ready.
//  - States / transitions:
//    FETCH: IorD=0 MemRead=1 ALUSrcA=0 ALUSrcB=01 ALUop=00 PCSrc=00; on mem_ready: IRWrite=1 PCWrite=1 (PC+1) -> DECODE
//    DECODE: ALUSrcA=0 ALUSrcB=10 ALUop=00 (branch target); 000000->EXEC_R, 100011/101011->MEM_ADDR,
//            000100->BRANCH, 001000->EXEC_I, 000010->JUMP, other->ERROR (illegal_op=1)
//    EXEC_R: ALUSrcA=1 ALUSrcB=00 ALUop=10 -> WB_R;   WB_R: RegDst=1 RegWrite=1 MemToReg=0 -> FETCH
//    EXEC_I: ALUSrcA=1 ALUSrcB=10 ALUop=00 -> WB_I;   WB_I: RegDst=0 RegWrite=1 MemToReg=0 -> FETCH
//    MEM_ADDR: ALUSrcA=1 ALUSrcB=10 ALUop=00; lw->MEM_RD, sw->MEM_WR
//    MEM_RD: IorD=1 MemRead=1; mem_ready -> WB_MEM;   WB_MEM: RegDst=0 RegWrite=1 MemToReg=1 -> FETCH
//    MEM_WR: IorD=1 MemWrite=1; mem_ready -> FETCH (retires)
//    BRANCH: ALUSrcA=1 ALUSrcB=00 ALUop=01 PCWriteCond=1 PCSrc=01 -> FETCH (retires, taken or not)
//    JUMP: PCWrite=1 PCSrc=10 -> FETCH;   ERROR: all outputs 0, absorbing until reset
//  - Latency (mem_ready immediate): R/addi 4, lw 5, sw 4, beq 3, j 3 cycles.
//  - Wait counter: clears on entering FETCH/MEM_RD/MEM_WR, increments each non-ready cycle; reaching
//    TIMEOUT-1 without mem_ready -> ERROR, mem_timeout=1. mem_ready on the last allowed cycle wins.
//  - instr_retired pulses on the final-state exit cycle to FETCH; retire_count increments same edge.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR ignored. Reset mid-instruction aborts it, no retire pulse.
// STRUCTURE
//  - Shared package/header mips_ctrl_defs: opcode constants, ALUop encodings, PCSrc/ALUSrcB encodings,
//    state encoding (4-bit localparams) reused by ALU control and the core.
//  - One natural sub-module: mem_wait_timer (counter + timeout compare); FSM and decode stay in top.
// TESTING
//  - add (op 000000), mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 RegDst=1 only in WB_R; retire_count=1.
//  - lw with mem_ready low 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles, WB_MEM MemToReg=1, 8 cycles total.
//  - beq, zero_flag=1 then 0 -> PCWriteCond=1 PCSrc=01 in BRANCH both times; 3 cycles each; both retire.
//  - opcode 111111 -> ERROR after DECODE, illegal_op=1, outputs 0 until reset; reset -> FETCH, flag 0.
//  - FETCH with mem_ready never high, TIMEOUT=16 -> ERROR on cycle 16, mem_timeout=1, IRWrite never 1.
//  - reset asserted in MEM_WR -> next cycle FETCH, MemWrite=0, no instr_retired, retire_count=0.

Source files
------------

// File: rtl/mips_ctrl_defs.sv
// rtl/mips_ctrl_defs.sv - shared opcode, mux-select, ALUop and state encodings for the multicycle MIPS control
//
// Purpose: one place for the constants that the main control FSM, the ALU control
// and the datapath must agree on.
// Contents:
//   OP_*     instruction[31:26] opcodes handled by the control FSM
//   ALUOP_*  ALUop encodings sent to the ALU control block
//   SRCB_*   ALUSrcB mux selects (11 is reserved and never driven)
//   PCSRC_*  PCSrc mux selects
//   ST_*     4-bit FSM state encodings
//   ctrl_t   bundle of every datapath control output
package mips_ctrl_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_WB_R     = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_WB_I     = 4'd5;
    localparam logic [3:0] ST_MEM_ADDR = 4'd6;
    localparam logic [3:0] ST_MEM_RD   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_MEM_WR   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_ERROR    = 4'd12;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // States that wait on the memory handshake and are covered by the wait timer.
    function automatic logic is_mem_wait_state(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts non-ready cycles of a memory access and flags the last allowed cycle
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset, clears the count
//   clear    in   restart the count (FSM is changing state this cycle)
//   advance  in   memory state waiting and mem_ready low this cycle
//   expired  out  count has reached TIMEOUT-1: this is the last cycle mem_ready may arrive
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // Clearing on every state change means each memory state starts from zero;
    // the FSM leaves the waiting state when expired, so the count never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM sequencing the shared multicycle MIPS datapath
//
// Purpose: walks each instruction through FETCH/DECODE/execute/memory/write-back states,
// driving every datapath enable and mux select as a Moore function of the state
// (IRWrite/PCWrite in FETCH are additionally qualified by mem_ready).
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   opcode                  instruction[31:26] from the IR
//   zero_flag               ALU zero flag (PCWriteCond is qualified by it outside this block)
//   mem_ready               memory completes the current access this cycle
//   IorD..PCSrc             datapath controls
//   instr_retired           one-cycle pulse on the exit cycle of an instruction's last state
//   retire_count            retired instructions since reset, wrapping
//   illegal_op, mem_timeout sticky error flags, cleared only by reset
module mips_multicycle_control
    import mips_ctrl_defs::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                MemToReg,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUop,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          PCSrc,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                illegal_op,
    output logic                mem_timeout
);

    logic [3:0]          state;
    logic [3:0]          state_next;
    logic                retire;
    logic                set_illegal;
    logic                set_timeout;
    logic                wait_expired;
    logic                wait_advance;
    logic                wait_clear;
    logic [RETIRE_W-1:0] retire_q;
    logic                illegal_q;
    logic                timeout_q;
    ctrl_t               ctrl;
    ctrl_t               ctrl_out;

    // The branch decision is taken in the datapath from PCWriteCond & zero_flag.
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;

    assign wait_advance = is_mem_wait_state(state) && !mem_ready;
    assign wait_clear   = (state_next != state);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (wait_clear),
        .advance (wait_advance),
        .expired (wait_expired)
    );

    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next  = ST_ERROR;
                    set_timeout = 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = ST_EXEC_R;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_EXEC_I;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        state_next  = ST_ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R:   state_next = ST_WB_R;
            ST_EXEC_I:   state_next = ST_WB_I;
            ST_MEM_ADDR: state_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_next = ST_WB_MEM;
                end else if (wait_expired) begin
                    state_next  = ST_ERROR;
                    set_timeout = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end else if (wait_expired) begin
                    state_next  = ST_ERROR;
                    set_timeout = 1'b1;
                end
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_FETCH;
            retire_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) begin
                retire_q <= retire_q + 1'b1;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_WB_I: begin
                ctrl.reg_write = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

    // Every output is forced low for the whole cycle reset is high, including
    // the first cycle before the registers have been cleared.
    assign ctrl_out = reset ? CTRL_IDLE : ctrl;

    assign IorD          = ctrl_out.iord;
    assign MemRead       = ctrl_out.mem_read;
    assign MemWrite      = ctrl_out.mem_write;
    assign IRWrite       = ctrl_out.ir_write;
    assign RegDst        = ctrl_out.reg_dst;
    assign RegWrite      = ctrl_out.reg_write;
    assign MemToReg      = ctrl_out.mem_to_reg;
    assign ALUSrcA       = ctrl_out.alu_src_a;
    assign ALUSrcB       = ctrl_out.alu_src_b;
    assign ALUop         = ctrl_out.alu_op;
    assign PCWrite       = ctrl_out.pc_write;
    assign PCWriteCond   = ctrl_out.pc_write_cond;
    assign PCSrc         = ctrl_out.pc_src;
    assign instr_retired = retire && !reset;
    assign retire_count  = reset ? '0 : retire_q;
    assign illegal_op    = illegal_q && !reset;
    assign mem_timeout   = timeout_q && !reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed table-driven bench for mips_multicycle_control
module tb_mips_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        zero_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemToReg, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUop, PCSrc;
    logic        PCWrite, PCWriteCond;
    logic        instr_retired, illegal_op, mem_timeout;
    logic [31:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    mips_multicycle_control #(
        .TIMEOUT  (16),
        .RETIRE_W (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .zero_flag     (zero_flag),
        .mem_ready     (mem_ready),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .MemToReg      (MemToReg),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUop         (ALUop),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .PCSrc         (PCSrc),
        .instr_retired (instr_retired),
        .retire_count  (retire_count),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    always #5 clock = ~clock;

    // Control word layout: IorD MemRead MemWrite IRWrite RegDst RegWrite MemToReg ALUSrcA
    //                      ALUSrcB[1:0] ALUop[1:0] PCWrite PCWriteCond PCSrc[1:0]
    logic [15:0] act_w;
    assign act_w = {IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemToReg, ALUSrcA,
                    ALUSrcB, ALUop, PCWrite, PCWriteCond, PCSrc};

    localparam logic [15:0] W_ZERO     = 16'b0;
    localparam logic [15:0] W_FETCH_NR = {8'b0100_0000, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_FETCH_RD = {8'b0101_0000, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00};
    localparam logic [15:0] W_DECODE   = {8'b0000_0000, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_EXEC_R   = {8'b0000_0001, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_WB_R     = {8'b0000_1100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_EXEC_I   = {8'b0000_0001, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_WB_I     = {8'b0000_0100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_MEM_RD   = {8'b1100_0000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_WB_MEM   = {8'b0000_0110, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_MEM_WR   = {8'b1010_0000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
    localparam logic [15:0] W_BRANCH   = {8'b0000_0001, 2'b00, 2'b01, 1'b0, 1'b1, 2'b01};
    localparam logic [15:0] W_JUMP     = {8'b0000_0000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10};

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] JP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zf;
        logic        rdy;
        logic [15:0] w;
        logic        ret;
        logic [31:0] cnt;
        logic        ill;
        logic        to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic zf, input logic rdy,
                                input logic [15:0] w, input logic ret, input logic [31:0] cnt,
                                input logic ill, input logic to);
        vec_t v;
        v.rst = rst; v.op = op; v.zf = zf; v.rdy = rdy;
        v.w = w; v.ret = ret; v.cnt = cnt; v.ill = ill; v.to = to;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check the settled outputs
    // before the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clock);
        reset     = v.rst;
        opcode    = v.op;
        zero_flag = v.zf;
        mem_ready = v.rdy;
        #2;
        check({tag, " ctrl"},    {16'b0, act_w},          {16'b0, v.w});
        check({tag, " retired"}, {31'b0, instr_retired},  {31'b0, v.ret});
        check({tag, " count"},   retire_count,            v.cnt);
        check({tag, " illegal"}, {31'b0, illegal_op},     {31'b0, v.ill});
        check({tag, " timeout"}, {31'b0, mem_timeout},    {31'b0, v.to});
    endtask

    initial begin
        // reset
        vecs.push_back(mk(1, R, 0, 1, W_ZERO, 0, 0, 0, 0));
        vecs.push_back(mk(1, R, 0, 1, W_ZERO, 0, 0, 0, 0));
        // add: 4 cycles
        vecs.push_back(mk(0, R, 0, 1, W_FETCH_RD, 0, 0, 0, 0));
        vecs.push_back(mk(0, R, 0, 1, W_DECODE,   0, 0, 0, 0));
        vecs.push_back(mk(0, R, 0, 1, W_EXEC_R,   0, 0, 0, 0));
        vecs.push_back(mk(0, R, 0, 1, W_WB_R,     1, 0, 0, 0));
        // addi: 4 cycles
        vecs.push_back(mk(0, AI, 0, 1, W_FETCH_RD, 0, 1, 0, 0));
        vecs.push_back(mk(0, AI, 0, 1, W_DECODE,   0, 1, 0, 0));
        vecs.push_back(mk(0, AI, 0, 1, W_EXEC_I,   0, 1, 0, 0));
        vecs.push_back(mk(0, AI, 0, 1, W_WB_I,     1, 1, 0, 0));
        // lw with three not-ready cycles in MEM_RD: 8 cycles
        vecs.push_back(mk(0, LW, 0, 1, W_FETCH_RD, 0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 1, W_DECODE,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 0, W_EXEC_I,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 0, W_MEM_RD,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 0, W_MEM_RD,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 0, W_MEM_RD,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 1, W_MEM_RD,   0, 2, 0, 0));
        vecs.push_back(mk(0, LW, 0, 0, W_WB_MEM,   1, 2, 0, 0));
        // sw: 4 cycles
        vecs.push_back(mk(0, SW, 0, 1, W_FETCH_RD, 0, 3, 0, 0));
        vecs.push_back(mk(0, SW, 0, 1, W_DECODE,   0, 3, 0, 0));
        vecs.push_back(mk(0, SW, 0, 1, W_EXEC_I,   0, 3, 0, 0));
        vecs.push_back(mk(0, SW, 0, 1, W_MEM_WR,   1, 3, 0, 0));
        // beq taken then not taken: 3 cycles each, both retire
        vecs.push_back(mk(0, BQ, 1, 1, W_FETCH_RD, 0, 4, 0, 0));
        vecs.push_back(mk(0, BQ, 1, 1, W_DECODE,   0, 4, 0, 0));
        vecs.push_back(mk(0, BQ, 1, 1, W_BRANCH,   1, 4, 0, 0));
        vecs.push_back(mk(0, BQ, 0, 1, W_FETCH_RD, 0, 5, 0, 0));
        vecs.push_back(mk(0, BQ, 0, 1, W_DECODE,   0, 5, 0, 0));
        vecs.push_back(mk(0, BQ, 0, 1, W_BRANCH,   1, 5, 0, 0));
        // j with one not-ready fetch cycle
        vecs.push_back(mk(0, JP, 0, 0, W_FETCH_NR, 0, 6, 0, 0));
        vecs.push_back(mk(0, JP, 0, 1, W_FETCH_RD, 0, 6, 0, 0));
        vecs.push_back(mk(0, JP, 0, 1, W_DECODE,   0, 6, 0, 0));
        vecs.push_back(mk(0, JP, 0, 1, W_JUMP,     1, 6, 0, 0));
        // illegal opcode: ERROR is absorbing until reset
        vecs.push_back(mk(0, BAD, 0, 1, W_FETCH_RD, 0, 7, 0, 0));
        vecs.push_back(mk(0, BAD, 0, 1, W_DECODE,   0, 7, 0, 0));
        vecs.push_back(mk(0, BAD, 0, 1, W_ZERO,     0, 7, 1, 0));
        vecs.push_back(mk(0, R,   0, 1, W_ZERO,     0, 7, 1, 0));
        vecs.push_back(mk(1, R,   0, 1, W_ZERO,     0, 0, 0, 0));
        vecs.push_back(mk(0, R,   0, 0, W_FETCH_NR, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Fetch never ready: 16 waiting cycles, then ERROR with mem_timeout.
        apply("to_rst", mk(1, R, 0, 0, W_ZERO, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++) begin
            apply($sformatf("to_wait%0d", k), mk(0, R, 0, 0, W_FETCH_NR, 0, 0, 0, 0));
        end
        apply("to_err0", mk(0, R, 0, 0, W_ZERO, 0, 0, 0, 1));
        apply("to_err1", mk(0, R, 0, 1, W_ZERO, 0, 0, 0, 1));

        // mem_ready on the last allowed fetch cycle still completes the fetch.
        apply("last_rst", mk(1, JP, 0, 0, W_ZERO, 0, 0, 0, 0));
        for (int k = 0; k < 15; k++) begin
            apply($sformatf("last_wait%0d", k), mk(0, JP, 0, 0, W_FETCH_NR, 0, 0, 0, 0));
        end
        apply("last_rdy",  mk(0, JP, 0, 1, W_FETCH_RD, 0, 0, 0, 0));
        apply("last_dec",  mk(0, JP, 0, 0, W_DECODE,   0, 0, 0, 0));
        apply("last_jump", mk(0, JP, 0, 0, W_JUMP,     1, 0, 0, 0));

        // Reset while a store waits in MEM_WR: aborted, no retire, count cleared.
        apply("sw_fetch", mk(0, SW, 0, 1, W_FETCH_RD, 0, 1, 0, 0));
        apply("sw_dec",   mk(0, SW, 0, 0, W_DECODE,   0, 1, 0, 0));
        apply("sw_addr",  mk(0, SW, 0, 0, W_EXEC_I,   0, 1, 0, 0));
        apply("sw_wait",  mk(0, SW, 0, 0, W_MEM_WR,   0, 1, 0, 0));
        apply("sw_rst",   mk(1, SW, 0, 1, W_ZERO,     0, 0, 0, 0));
        apply("sw_after", mk(0, SW, 0, 0, W_FETCH_NR, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
